// File: rtl/uart_rx.sv
// 8/N/1 UART receiver with 2-flop line synchronizer and one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority around bit centre.
module uart_rx #(
    parameter int CLK_FREQ     = 250000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_sync;
    logic          w_line;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_cnt_zero;
    logic          w_sample;
    logic          w_done;
    logic          w_ferr;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    // Synchronizer resets to the idle level so release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_in};
    end

    assign w_line     = r_sync[1];
    assign w_cnt_zero = (r_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
    logic r_m2, r_m1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m2 <= 1'b1;
            r_m1 <= 1'b1;
        end else begin
            if (r_cnt == CW'(2)) r_m2 <= w_line;
            if (r_cnt == CW'(1)) r_m1 <= w_line;
        end
    end

    assign w_sample = (r_m2 & r_m1) | (r_m2 & w_line) | (r_m1 & w_line);
`else
    assign w_sample = w_line;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_line) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = HALF_LOAD;
                end
            end
            S_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_sample) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = FULL_LOAD;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt = {w_sample, r_shift[7:1]};
                    w_cnt_nxt   = FULL_LOAD;
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_sample) begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (w_line) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A completed byte may load into a full register only if it drains in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_done) begin
                if (!r_valid || i_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != S_IDLE);

endmodule
